decode_stage: RTL and testbench

Second pipeline stage. Consumes the fetch stage's instruction word and address, decodes RV32I fields, generates the sign-extended immediate, reads the register file, and presents a registered decode packet to execute. A two-entry output buffer (output register + skid register) fully registers the backpressure signal returned to fetch. Redirects from writeback (`jmp_tk`) flush all held entries.

---
 rtl/decode_stage_pkg.sv | 84 ++++++++
 rtl/decode_stage_if.sv | 37 +++
 rtl/decode_stage_regfile.sv | 37 +++
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared types, opcode constants and immediate generation for the decode stage.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (illegal-opcode flag).
package decode_stage_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_OP       = 7'h33;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} buf_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr_addr;
  } f_d_WI;

  typedef struct packed {
    logic            jmp_tk;
    logic [XLEN-1:0] jmp_addr;
  } w_f_WI;

  typedef struct packed {
    logic [XLEN-1:0] instr_addr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_dat;
    logic [XLEN-1:0] rs2_dat;
  } d_e_WI;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    imm_fmt_e f;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: f = IMM_I;
      OP_STORE:                 f = IMM_S;
      OP_BRANCH:                f = IMM_B;
      OP_LUI, OP_AUIPC:         f = IMM_U;
      OP_JAL:                   f = IMM_J;
      default:                  f = IMM_NONE;
    endcase
    return f;
  endfunction

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] instr);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (imm_fmt(instr[6:0]))
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Every supported opcode ends in 2'b11, so this also rejects compressed encodings.
  function automatic logic opcode_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute/writeback signal bundle for the decode stage.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN adds the illegal flag.
interface decode_stage_if;
  import decode_stage_pkg::*;

  f_d_WI           f_in;
  logic [XLEN-1:0] instr_dat_in;
  logic            f_v;
  logic            stall_out_dc;
  w_f_WI           w_in;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_dat;
  logic            stall_in_ex;
  d_e_WI           d_out;
  logic            d_v;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic            illegal;
`endif

  modport slave (
    input  f_in, instr_dat_in, f_v, w_in, wb_en, wb_rd, wb_dat, stall_in_ex,
    output stall_out_dc, d_out, d_v
`ifdef DECODE_ILLEGAL_CHECK_EN
    , illegal
`endif
  );

  modport master (
    output f_in, instr_dat_in, f_v, w_in, wb_en, wb_rd, wb_dat, stall_in_ex,
    input  stall_out_dc, d_out, d_v
`ifdef DECODE_ILLEGAL_CHECK_EN
    , illegal
`endif
  );

endinterface

// File: rtl/decode_stage_regfile.sv
// NREG x XLEN register file: two async read ports with write-through, one sync
// write port, x0 hardwired to zero, synchronous reset clears every entry.
module decode_stage_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Same-cycle writes are forwarded so a reader never sees the stale value.
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (ra1_i != '0) rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : mem_q[ra1_i];
    if (ra2_i != '0) rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : mem_q[ra2_i];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, register read, and a two-entry
// output+skid buffer so stall_out_dc is fully registered. Macro: DECODE_ILLEGAL_CHECK_EN.
module decode_stage
  import decode_stage_pkg::*;
(
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  buf_state_e      state_q, state_d;
  d_e_WI           out_q, out_d, skid_q, skid_d;
  d_e_WI           new_pkt, out_byp, skid_byp;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_rd, rs2_rd;
  logic            jmp_tk, accept, advance;
  logic            load_out_new, load_out_skid, load_skid_new;
  logic            unused_jmp_addr;

  assign instr           = bus.instr_dat_in;
  assign jmp_tk          = bus.w_in.jmp_tk;
  assign unused_jmp_addr = ^bus.w_in.jmp_addr;

  decode_stage_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (instr[19:15]),
    .ra2_i (instr[24:20]),
    .rd1_o (rs1_rd),
    .rd2_o (rs2_rd),
    .we_i  (bus.wb_en),
    .wa_i  (bus.wb_rd),
    .wd_i  (bus.wb_dat)
  );

  always_comb begin
    new_pkt            = '0;
    new_pkt.instr_addr = bus.f_in.instr_addr;
    new_pkt.opcode     = instr[6:0];
    new_pkt.rd         = instr[11:7];
    new_pkt.funct3     = instr[14:12];
    new_pkt.rs1        = instr[19:15];
    new_pkt.rs2        = instr[24:20];
    new_pkt.funct7     = instr[31:25];
    new_pkt.imm        = imm_gen(instr);
    new_pkt.rs1_dat    = rs1_rd;
    new_pkt.rs2_dat    = rs2_rd;
  end

  // Entries waiting on execute must still observe writebacks to their sources.
  function automatic d_e_WI held_bypass(input d_e_WI e, input logic we,
                                        input logic [4:0] wa, input logic [XLEN-1:0] wd);
    d_e_WI r;
    r = e;
    if (we && (wa != 5'd0)) begin
      if (e.rs1 == wa) r.rs1_dat = wd;
      if (e.rs2 == wa) r.rs2_dat = wd;
    end
    return r;
  endfunction

  assign out_byp  = held_bypass(out_q,  bus.wb_en, bus.wb_rd, bus.wb_dat);
  assign skid_byp = held_bypass(skid_q, bus.wb_en, bus.wb_rd, bus.wb_dat);

  assign bus.d_v          = (state_q != S_EMPTY);
  assign bus.stall_out_dc = (state_q == S_TWO);
  assign bus.d_out        = out_q;
  assign accept           = bus.f_v && !bus.stall_out_dc && !jmp_tk;
  assign advance          = bus.d_v && !bus.stall_in_ex;

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid_new = 1'b0;
    case (state_q)
      S_EMPTY: if (accept) begin
        state_d      = S_ONE;
        load_out_new = 1'b1;
      end
      S_ONE: begin
        if (accept && advance) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_d       = S_TWO;
          load_skid_new = 1'b1;
        end else if (advance) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: if (advance) begin
        state_d       = S_ONE;
        load_out_skid = 1'b1;
      end
      default: state_d = S_EMPTY;
    endcase
    if (jmp_tk) state_d = S_EMPTY;
  end

  always_comb begin
    out_d  = out_byp;
    skid_d = skid_byp;
    if (load_out_new)       out_d = new_pkt;
    else if (load_out_skid) out_d = skid_byp;
    if (load_skid_new)      skid_d = new_pkt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic new_ill, out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;

  assign new_ill     = !opcode_legal(instr[6:0]);
  assign bus.illegal = bus.d_v && out_ill_q;

  always_comb begin
    out_ill_d  = out_ill_q;
    skid_ill_d = skid_ill_q;
    if (load_out_new)       out_ill_d = new_ill;
    else if (load_out_skid) out_ill_d = skid_ill_q;
    if (load_skid_new)      skid_ill_d = new_ill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ill_q  <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      out_ill_q  <= out_ill_d;
      skid_ill_q <= skid_ill_d;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, hand-written
// stall/flush/bypass/reset sequences, and a randomized run against a queue model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if bus();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
  } vec_t;
  vec_t vecs[9];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ill;
  } mpkt_t;
  mpkt_t       mq[$];
  logic [31:0] mrf[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.f_v              = 1'b0;
    bus.instr_dat_in     = '0;
    bus.f_in.instr_addr  = '0;
    bus.w_in.jmp_tk      = 1'b0;
    bus.w_in.jmp_addr    = '0;
    bus.wb_en            = 1'b0;
    bus.wb_rd            = '0;
    bus.wb_dat           = '0;
    bus.stall_in_ex      = 1'b0;
  endtask

  task automatic offer(input logic [31:0] w, input logic [31:0] a);
    bus.f_v             = 1'b1;
    bus.instr_dat_in    = w;
    bus.f_in.instr_addr = a;
  endtask

  // Reference immediate built from field arithmetic on the raw word.
  function automatic longint sx(input longint x, input int n);
    if ((x >> (n - 1)) & 1) return x - (longint'(1) << n);
    return x;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    longint u, v;
    u = longint'(w);
    v = 0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: v = sx(u >> 20, 12);
      7'h23: v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      7'h63: v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                    (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      7'h37, 7'h17: v = u & 64'hFFFFF000;
      7'h6F: v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                    (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic ref_ill(input logic [31:0] w);
    case (w[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return mrf[r];
  endfunction

  function automatic logic [31:0] gen_word();
    logic [6:0]  ops[12];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B, 7'h2A, 7'h00};
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic check_model();
    chk("rnd_dv", 32'(bus.d_v), 32'(mq.size() != 0));
    chk("rnd_stall", 32'(bus.stall_out_dc), 32'(mq.size() == 2));
    if (mq.size() != 0) begin
      chk("rnd_addr",   bus.d_out.instr_addr, mq[0].addr);
      chk("rnd_opcode", 32'(bus.d_out.opcode), mq[0].instr & 32'h7F);
      chk("rnd_rd",     32'(bus.d_out.rd),     (mq[0].instr >> 7) & 32'h1F);
      chk("rnd_f3",     32'(bus.d_out.funct3), (mq[0].instr >> 12) & 32'h7);
      chk("rnd_rs1",    32'(bus.d_out.rs1),    (mq[0].instr >> 15) & 32'h1F);
      chk("rnd_rs2",    32'(bus.d_out.rs2),    (mq[0].instr >> 20) & 32'h1F);
      chk("rnd_f7",     32'(bus.d_out.funct7), mq[0].instr >> 25);
      chk("rnd_imm",    bus.d_out.imm,         ref_imm(mq[0].instr));
      chk("rnd_rs1dat", bus.d_out.rs1_dat,     mq[0].r1);
      chk("rnd_rs2dat", bus.d_out.rs2_dat,     mq[0].r2);
    end
`ifdef DECODE_ILLEGAL_CHECK_EN
    chk("rnd_illegal", 32'(bus.illegal), 32'(mq.size() != 0 && mq[0].ill));
`endif
  endtask

  initial begin
    logic [31:0] w_instr, w_addr;
    logic        have, acc, adv;
    mpkt_t       np;

    vecs[0] = '{32'hFFB00093, 32'h40, 32'hFFFFFFFB, 5'd1,  7'h13};
    vecs[1] = '{32'h123452B7, 32'h44, 32'h12345000, 5'd5,  7'h37};
    vecs[2] = '{32'hFE20AE23, 32'h48, 32'hFFFFFFFC, 5'h1C, 7'h23};
    vecs[3] = '{32'hFE000CE3, 32'h4C, 32'hFFFFFFF8, 5'h19, 7'h63};
    vecs[4] = '{32'h001000EF, 32'h50, 32'h00000800, 5'd1,  7'h6F};
    vecs[5] = '{32'hFFFFF197, 32'h54, 32'hFFFFF000, 5'd3,  7'h17};
    vecs[6] = '{32'h00318233, 32'h58, 32'h00000000, 5'd4,  7'h33};
    vecs[7] = '{32'hFFFFF06F, 32'h5C, 32'hFFFFFFFE, 5'd0,  7'h6F};
    vecs[8] = '{32'h00008067, 32'h60, 32'h00000000, 5'd0,  7'h67};

    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_dv", 32'(bus.d_v), 32'd0);
    chk("rst_stall", 32'(bus.stall_out_dc), 32'd0);
    chk("rst_dout_zero", 32'(bus.d_out == '0), 32'd1);

    foreach (vecs[i]) begin
      offer(vecs[i].instr, vecs[i].addr);
      step();
      bus.f_v = 1'b0;
      chk("vec_dv", 32'(bus.d_v), 32'd1);
      chk("vec_imm", bus.d_out.imm, vecs[i].imm);
      chk("vec_rd", 32'(bus.d_out.rd), 32'(vecs[i].rd));
      chk("vec_opcode", 32'(bus.d_out.opcode), 32'(vecs[i].op));
      chk("vec_addr", bus.d_out.instr_addr, vecs[i].addr);
      step();
      chk("vec_drain_dv", 32'(bus.d_v), 32'd0);
    end

    // Three back-to-back words into a stalled execute.
    bus.stall_in_ex = 1'b1;
    offer(32'h00000013, 32'h100);
    step();
    chk("bb_stall_after1", 32'(bus.stall_out_dc), 32'd0);
    offer(32'h00000013, 32'h104);
    step();
    chk("bb_stall_after2", 32'(bus.stall_out_dc), 32'd1);
    offer(32'h00000013, 32'h108);
    step();
    chk("bb_stall_held", 32'(bus.stall_out_dc), 32'd1);
    chk("bb_head_held", bus.d_out.instr_addr, 32'h100);
    bus.stall_in_ex = 1'b0;
    step();
    chk("bb_second", bus.d_out.instr_addr, 32'h104);
    chk("bb_stall_clear", 32'(bus.stall_out_dc), 32'd0);
    step();
    bus.f_v = 1'b0;
    chk("bb_third", bus.d_out.instr_addr, 32'h108);
    chk("bb_third_dv", 32'(bus.d_v), 32'd1);
    step();
    chk("bb_no_dup", 32'(bus.d_v), 32'd0);

    // Write-through on accept, then bypass into a held entry.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_dat = 32'h1234;
    offer(32'h00318233, 32'h200);
    step();
    idle();
    chk("wt_rs1", bus.d_out.rs1_dat, 32'h1234);
    chk("wt_rs2", bus.d_out.rs2_dat, 32'h1234);
    step();
    bus.stall_in_ex = 1'b1;
    offer(32'h00318233, 32'h204);
    step();
    bus.f_v = 1'b0;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_dat = 32'h5678;
    step();
    bus.wb_en = 1'b0;
    chk("held_rs1", bus.d_out.rs1_dat, 32'h5678);
    chk("held_rs2", bus.d_out.rs2_dat, 32'h5678);
    chk("held_dv", 32'(bus.d_v), 32'd1);
    bus.stall_in_ex = 1'b0;
    step();
    chk("held_drain", 32'(bus.d_v), 32'd0);

    // Redirect while both entries are full, with a simultaneous regfile write.
    bus.stall_in_ex = 1'b1;
    offer(32'h00000013, 32'h300);
    step();
    offer(32'h00000013, 32'h304);
    step();
    chk("jmp_pre_stall", 32'(bus.stall_out_dc), 32'd1);
    offer(32'h00000013, 32'h308);
    bus.w_in.jmp_tk = 1'b1;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_dat = 32'hABCD;
    step();
    idle();
    chk("jmp_dv", 32'(bus.d_v), 32'd0);
    chk("jmp_stall", 32'(bus.stall_out_dc), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("jmp_no_ghost", 32'(bus.d_v), 32'd0);
    end
    offer(32'h00738433, 32'h30C);
    step();
    bus.f_v = 1'b0;
    chk("jmp_wb_kept", bus.d_out.rs1_dat, 32'hABCD);
    step();

    // Reset while stalled with both entries full; reset also clears the regfile.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_dat = 32'h55;
    step();
    bus.wb_en = 1'b0;
    bus.stall_in_ex = 1'b1;
    offer(32'h00000013, 32'h400);
    step();
    offer(32'h00000013, 32'h404);
    step();
    chk("rst2_pre_stall", 32'(bus.stall_out_dc), 32'd1);
    rst = 1'b1;
    bus.w_in.jmp_tk = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("rst2_dv", 32'(bus.d_v), 32'd0);
    chk("rst2_stall", 32'(bus.stall_out_dc), 32'd0);
    offer(32'h00528333, 32'h408);
    step();
    bus.f_v = 1'b0;
    chk("rst2_x5", bus.d_out.rs1_dat, 32'd0);
    step();

`ifdef DECODE_ILLEGAL_CHECK_EN
    offer(32'h00000000, 32'h500);
    step();
    chk("ill_zero", 32'(bus.illegal), 32'd1);
    offer(32'h00000013, 32'h504);
    step();
    bus.f_v = 1'b0;
    chk("ill_nop", 32'(bus.illegal), 32'd0);
    step();
    chk("ill_idle", 32'(bus.illegal), 32'd0);
`endif

    // Randomized traffic against the queue model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    mq.delete();
    foreach (mrf[i]) mrf[i] = 32'd0;
    have   = 1'b0;
    w_instr = '0;
    w_addr  = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      if (!have) begin
        w_instr = gen_word();
        w_addr  = w_addr + 32'd4;
        have    = 1'b1;
      end
      offer(w_instr, w_addr);
      bus.f_v           = ($urandom_range(0, 3) != 0);
      bus.w_in.jmp_tk   = ($urandom_range(0, 15) == 0);
      bus.w_in.jmp_addr = $urandom;
      bus.wb_en         = ($urandom_range(0, 1) == 1);
      bus.wb_rd         = 5'($urandom_range(0, 7));
      bus.wb_dat        = $urandom;
      bus.stall_in_ex   = ($urandom_range(0, 9) < 4);
      rst               = ($urandom_range(0, 99) == 0);

      acc = bus.f_v && (mq.size() < 2) && !bus.w_in.jmp_tk;
      adv = (mq.size() != 0) && !bus.stall_in_ex;
      if (rst) begin
        mq.delete();
        foreach (mrf[i]) mrf[i] = 32'd0;
      end else begin
        foreach (mq[i]) begin
          if (bus.wb_en && bus.wb_rd != 5'd0) begin
            if (mq[i].instr[19:15] == bus.wb_rd) mq[i].r1 = bus.wb_dat;
            if (mq[i].instr[24:20] == bus.wb_rd) mq[i].r2 = bus.wb_dat;
          end
        end
        np.addr  = w_addr;
        np.instr = w_instr;
        np.r1    = ref_read(w_instr[19:15], bus.wb_en, bus.wb_rd, bus.wb_dat);
        np.r2    = ref_read(w_instr[24:20], bus.wb_en, bus.wb_rd, bus.wb_dat);
        np.ill   = ref_ill(w_instr);
        if (bus.w_in.jmp_tk) begin
          mq.delete();
        end else begin
          if (adv) void'(mq.pop_front());
          if (acc) mq.push_back(np);
        end
        if (bus.wb_en && bus.wb_rd != 5'd0) mrf[bus.wb_rd] = bus.wb_dat;
      end
      if ((acc && !rst) || (bus.f_v && bus.w_in.jmp_tk)) have = 1'b0;

      step();
      rst = 1'b0;
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
